// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the arbiter state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the UART TX arbiter: per-requester byte streams in,
// handshake, serial line and grant status out.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [UART_DATA_BITS*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]                req_last;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              tx;
  logic                              busy;
  logic                              grant_valid;
  logic [ID_W-1:0]                   grant_id;

  // Requesters / board side.
  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, tx, busy, grant_valid, grant_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, tx, busy, grant_valid, grant_id
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer. A start request is taken only while idle; the frame then
// runs for exactly UART_FRAME_BITS * CLKS_PER_BIT cycles and done marks the
// final stop-bit cycle. tx is registered and forced high by reset.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      tx,
  output logic                      done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(UART_FRAME_BITS - 1);

  logic                      r_busy;
  logic [BAUD_W-1:0]         r_baud;
  logic [3:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx;
  logic                      w_bit_end;

  assign w_bit_end = r_busy && (r_baud == BAUD_LAST);
  assign done      = w_bit_end && (r_bit_idx == BIT_LAST);
  assign tx        = r_tx;

  // Baud counter, bit index and shift register; the shifter back-fills ones
  // so the stop bit falls out of the same path as the data bits.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else if (!r_busy) begin
      if (start) begin
        r_busy    <= 1'b1;
        r_baud    <= '0;
        r_bit_idx <= '0;
        r_shift   <= data;
        r_tx      <= 1'b0;
      end
    end else if (w_bit_end) begin
      r_baud <= '0;
      if (r_bit_idx == BIT_LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_bit_idx <= r_bit_idx + 4'd1;
        r_tx      <= r_shift[0];
        r_shift   <= {1'b1, r_shift[UART_DATA_BITS-1:1]};
      end
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX line between NUM_REQ byte streams. Round-robin grant,
// held for a whole packet but at most MAX_BURST bytes; a split packet
// re-arbitrates behind everyone else because rr_ptr moves past the owner.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int MAX_BURST    = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int                 ID_W      = $clog2(NUM_REQ);
  localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]      NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

  arb_state_t                r_state;
  logic [ID_W-1:0]           r_grant_id;
  logic                      r_grant_valid;
  logic [ID_W-1:0]           r_rr_ptr;
  logic [BURST_W-1:0]        r_burst_cnt;
  logic                      r_last;

  logic [ID_W-1:0]           w_pick_id;
  logic                      w_found;
  logic [ID_W:0]             w_sum;
  logic [ID_W:0]             w_cand;
  logic                      w_any_valid;
  logic                      w_xfer;
  logic [UART_DATA_BITS-1:0] w_sel_data;
  logic [NUM_REQ-1:0]        w_ready;
  logic                      w_serial_tx;
  logic                      w_serial_done;

  assign w_any_valid = |bus.req_valid;
  assign w_xfer      = (r_state == LOAD) && bus.req_valid[r_grant_id];

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  // NOTE: every signal driven here gets a default before the loop; without
  // it a path that assigns nothing would infer a latch.
  always_comb begin
    w_pick_id = r_rr_ptr;
    w_found   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum  = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
      w_cand = (w_sum >= NUM_REQ_W) ? (w_sum - NUM_REQ_W) : w_sum;
      if (!w_found && bus.req_valid[w_cand[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_pick_id = w_cand[ID_W-1:0];
      end
    end
  end

  // Byte of the current owner, handed to the serializer on transfer.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant_id == ID_W'(k)) begin
        w_sel_data = bus.req_data[k*UART_DATA_BITS +: UART_DATA_BITS];
      end
    end
  end

  // Ready reflects the owner's valid while loading; nobody else is ever ready.
  always_comb begin
    w_ready = '0;
    if (r_state == LOAD) begin
      w_ready[r_grant_id] = bus.req_valid[r_grant_id];
    end
  end

  // Grant FSM: arbitration, packet lock, burst limit and pointer rotation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_rr_ptr      <= '0;
      r_burst_cnt   <= '0;
      r_last        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_grant_id    <= w_pick_id;
            r_grant_valid <= 1'b1;
            r_burst_cnt   <= '0;
            r_state       <= LOAD;
          end
        end
        LOAD: begin
          if (w_xfer) begin
            r_last      <= bus.req_last[r_grant_id];
            r_burst_cnt <= r_burst_cnt + 1'b1;
            r_state     <= SEND;
          end else begin
            r_state <= RELEASE;
          end
        end
        SEND: begin
          if (w_serial_done) begin
            if (r_last || (r_burst_cnt == BURST_MAX)) begin
              r_state <= RELEASE;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        RELEASE: begin
          if (r_grant_id == LAST_ID) begin
            r_rr_ptr <= '0;
          end else begin
            r_rr_ptr <= r_grant_id + 1'b1;
          end
          r_grant_valid <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serializer (
    .clk   (clk),
    .reset (reset),
    .start (w_xfer),
    .data  (w_sel_data),
    .tx    (w_serial_tx),
    .done  (w_serial_done)
  );

  assign bus.req_ready   = w_ready;
  assign bus.tx          = w_serial_tx;
  assign bus.busy        = (r_state != IDLE);
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_id    = r_grant_id;

  // Structural invariants of the grant logic.
  a_burst_bound : assert property (@(posedge clk) disable iff (reset)
    r_burst_cnt <= BURST_MAX);
  a_ready_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(w_ready));
  a_ready_needs_grant : assert property (@(posedge clk) disable iff (reset)
    (|w_ready) |-> r_grant_valid);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Requesters are fed from per-port
// byte queues; a line monitor decodes every frame on tx, and a transaction
// level round-robin model predicts which requester/byte each frame carries.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int CPB       = 4;
  localparam int MAX_BURST = 4;
  localparam int FRAME_CYC = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    int         gid;
    int         start;
    logic [9:0] bits;
    bit         stable;
  } frame_t;

  typedef struct {
    int         gid;
    logic [7:0] data;
    bit         first;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ready_cnt = 0;
  int         illegal_cnt = 0;
  int         model_rr = 0;
  logic [8:0] q [NUM_REQ][$];   // {last, data} per requester
  frame_t     frames [$];
  exp_t       expq [$];

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .CLKS_PER_BIT (CPB),
    .MAX_BURST    (MAX_BURST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Requesters: present the head of each queue, pop it once accepted.
  initial begin : driver
    logic [NUM_REQ-1:0] xfer;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      xfer = bus.req_valid & bus.req_ready;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i] === 1'b1) begin
          if (bus.req_valid[i]) ready_cnt++;
          else illegal_cnt++;
        end
      end
      if (!$onehot0(bus.req_ready)) illegal_cnt++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (q[i].size() > 0) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[i*8 +: 8] = q[i][0][7:0];
          bus.req_last[i]        = q[i][0][8];
        end else begin
          bus.req_valid[i]       = 1'b0;
          bus.req_data[i*8 +: 8] = '0;
          bus.req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Line monitor: on a start bit, capture a full frame cycle by cycle.
  initial begin : monitor
    logic [FRAME_CYC-1:0] s;
    frame_t               f;
    bit                   aborted;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.tx === 1'b0) begin
        f.start = cyc;
        f.gid   = int'(bus.grant_id);
        s       = '0;
        s[0]    = bus.tx;
        aborted = 1'b0;
        for (int c = 1; c < FRAME_CYC && !aborted; c++) begin
          @(negedge clk);
          if (reset !== 1'b0) aborted = 1'b1;
          else s[c] = bus.tx;
        end
        if (!aborted) begin
          f.stable = 1'b1;
          for (int k = 0; k < 10; k++) begin
            f.bits[k] = s[k*CPB];
            for (int j = 0; j < CPB; j++)
              if (s[k*CPB+j] !== s[k*CPB]) f.stable = 1'b0;
          end
          f.data = f.bits[8:1];
          frames.push_back(f);
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "time limit reached");
  end

  task automatic get_frame(output frame_t f, output bit ok);
    ok = 1'b0;
    f  = '{default: 0};
    for (int c = 0; c < FRAME_CYC + 40; c++) begin
      if (frames.size() > 0) begin
        f  = frames.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Transaction-level model: grant the first non-empty queue from rr, send
  // until packet end, burst limit or an empty queue, then rotate past it.
  task automatic build_expected();
    logic [8:0] mq [NUM_REQ][$];
    logic [8:0] b;
    int         rr, k, n, c;
    exp_t       e;
    for (int i = 0; i < NUM_REQ; i++) mq[i] = q[i];
    expq.delete();
    rr = model_rr;
    forever begin
      k = -1;
      for (int j = 0; j < NUM_REQ; j++) begin
        c = (rr + j) % NUM_REQ;
        if (k < 0 && mq[c].size() > 0) k = c;
      end
      if (k < 0) break;
      n = 0;
      while (mq[k].size() > 0 && n < MAX_BURST) begin
        b       = mq[k].pop_front();
        e.gid   = k;
        e.data  = b[7:0];
        e.first = (n == 0);
        expq.push_back(e);
        n++;
        if (b[8]) break;
      end
      rr = (k + 1) % NUM_REQ;
    end
    model_rr = rr;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    int left = 0;
    while (c < 40 && (bus.busy !== 1'b0 || bus.grant_valid !== 1'b0)) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_idle"}, {bus.busy, bus.grant_valid}, 2'b00);
    for (int i = 0; i < NUM_REQ; i++) left += q[i].size();
    check({tag, "_drained"}, left, 0);
  endtask

  task automatic run_round(input string tag);
    frame_t f;
    exp_t   e;
    bit     ok;
    int     r0, i0, last_start;
    string  gname;
    build_expected();
    r0 = ready_cnt;
    i0 = illegal_cnt;
    last_start = -1;
    foreach (expq[n]) begin
      e = expq[n];
      get_frame(f, ok);
      check({tag, "_frame_seen"}, ok, 1);
      if (!ok) break;
      check({tag, "_data"}, f.data, e.data);
      check({tag, "_gid"}, f.gid, e.gid);
      check({tag, "_framing"}, {f.stable, f.bits[9], f.bits[0]}, 3'b110);
      if (last_start >= 0) begin
        if (e.first) gname = "_handover_gap";
        else gname = "_burst_gap";
        check({tag, gname}, f.start - last_start - FRAME_CYC, e.first ? 3 : 1);
      end
      last_start = f.start;
    end
    wait_idle(tag);
    check({tag, "_ready_pulses"}, ready_cnt - r0, expq.size());
    check({tag, "_ready_illegal"}, illegal_cnt - i0, 0);
  endtask

  task automatic push_packet(input int id, input int len);
    for (int b = 0; b < len; b++)
      q[id].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
  endtask

  initial begin : main
    frame_t     f;
    bit         ok;
    int         t_valid, t_ready, t_start, t_idle, n_rdy, total, s;
    logic       gv_at;
    logic [1:0] gid_at;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_grant_valid", bus.grant_valid, 1'b0);
    check("rst_grant_id", bus.grant_id, 2'd0);
    check("rst_ready", bus.req_ready, 4'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Fairness from reset: expect grants 0,1,2,3,0.
    q[0].push_back({1'b1, 8'h10});
    q[0].push_back({1'b1, 8'h14});
    q[1].push_back({1'b1, 8'h21});
    q[2].push_back({1'b1, 8'h32});
    q[3].push_back({1'b1, 8'h43});
    run_round("fair");

    // Single byte 0xA5 from requester 1 with cycle-exact timing.
    q[1].push_back({1'b1, 8'hA5});
    t_valid = -1; t_ready = -1; t_start = -1; t_idle = -1; n_rdy = 0;
    gv_at = 1'b0; gid_at = '0;
    for (int c = 0; c < 120 && t_idle < 0; c++) begin
      @(negedge clk);
      if (t_valid < 0 && bus.req_valid[1]) t_valid = cyc;
      if (bus.req_ready[1] === 1'b1) begin
        n_rdy++;
        if (t_ready < 0) begin
          t_ready = cyc;
          gv_at   = bus.grant_valid;
          gid_at  = bus.grant_id;
        end
      end
      if (t_start < 0 && bus.tx === 1'b0) t_start = cyc;
      if (t_start >= 0 && bus.busy === 1'b0) t_idle = cyc;
    end
    check("single_ready_at", t_ready - t_valid, 1);
    check("single_ready_pulses", n_rdy, 1);
    check("single_grant", {gv_at, gid_at}, 3'b101);
    check("single_start_at", t_start - t_valid, 2);
    check("single_busy_drop", t_idle - t_valid, 2 + FRAME_CYC - 1 + 2);
    get_frame(f, ok);
    check("single_frame_seen", ok, 1);
    check("single_bits", f.bits, 10'b1101001010);
    check("single_bit_hold", f.stable, 1'b1);
    model_rr = 2;

    // Packet lock: 3-byte packet from req2 while req0 waits.
    push_packet(2, 3);
    push_packet(0, 1);
    run_round("lock");

    // Move the pointer to 2, then split a 6-byte packet around req1.
    push_packet(1, 1);
    run_round("rotate");
    push_packet(3, 6);
    push_packet(1, 2);
    run_round("burst");

    // Randomized traffic.
    for (int r = 0; r < 4; r++) begin
      total = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int p = $urandom_range(0, 2); p > 0; p--) begin
          s = $urandom_range(1, 6);
          push_packet(i, s);
          total += s;
        end
      end
      if (total == 0) push_packet($urandom_range(0, NUM_REQ - 1), 3);
      run_round($sformatf("rand%0d", r));
    end

    // Requester stall: req0 stops after a non-last byte, then returns.
    q[0].push_back({1'b0, 8'h5A});
    run_round("stall");
    q[0].push_back({1'b1, 8'hC3});
    q[1].push_back({1'b1, 8'h7E});
    run_round("stall_return");

    // Reset during data bit 3 of a frame from req2.
    q[2].push_back({1'b1, 8'h3C});
    s = -1;
    for (int c = 0; c < 60 && s < 0; c++) begin
      @(negedge clk);
      if (bus.tx === 1'b0) s = cyc;
    end
    check("midrst_frame_started", (s >= 0), 1'b1);
    repeat (4 * CPB + 1) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", bus.tx, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_grant_valid", bus.grant_valid, 1'b0);
    check("midrst_grant_id", bus.grant_id, 2'd0);
    check("midrst_ready", bus.req_ready, 4'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("midrst_no_frame", frames.size(), 0);
    check("midrst_line_idle", {bus.tx, bus.busy}, 2'b10);
    model_rr = 0;
    q[1].push_back({1'b1, 8'h96});
    run_round("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
